// File: rtl/temperature_to_adc_encoder_pkg.sv
// Shared constants and state encoding for the temperature-to-ADC inverse encoder.
// Widths here match the forward temperature calculator path.
package temperature_to_adc_encoder_pkg;

    localparam int SCALE_SHIFT_DEF = 6;
    localparam int TEMP_W          = 32;
    localparam int REF_W           = 8;
    localparam int SQ_W            = 2 * REF_W;
    localparam int ADC_W           = 16;

    localparam logic [ADC_W-2:0] ADC_MAG_MAX = 15'h7FFF;

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_SQUARE = 2'd1,
        ST_DIVIDE = 2'd2,
        ST_DONE   = 2'd3
    } state_t;

    // Magnitude of a two's complement value; 0x80000000 maps to itself.
    function automatic logic [TEMP_W-1:0] abs_wrap(input logic [TEMP_W-1:0] v);
        return v[TEMP_W-1] ? (TEMP_W'(0) - v) : v;
    endfunction

endpackage

// File: rtl/temperature_to_adc_encoder_if.sv
// Request/response bundle of the encoder: operands and start in, handshake and result out.
interface temperature_to_adc_encoder_if;
    import temperature_to_adc_encoder_pkg::*;

    logic              start;
    logic [TEMP_W-1:0] tc_base;
    logic [REF_W-1:0]  tc_ref;
    logic [TEMP_W-1:0] tempc;
    logic              busy;
    logic              done;
    logic [ADC_W-1:0]  adc_data;
    logic              overflow;
    logic              div_zero;

    modport master (
        output start, tc_base, tc_ref, tempc,
        input  busy, done, adc_data, overflow, div_zero
    );

    modport slave (
        input  start, tc_base, tc_ref, tempc,
        output busy, done, adc_data, overflow, div_zero
    );

endinterface

// File: rtl/temperature_to_adc_encoder_seq_restoring_divider.sv
// Sequential restoring divider producing one quotient bit per cycle, MSB first.
// The loading edge already performs the first iteration, so DVD_W edges in total.
module seq_restoring_divider #(
    parameter int DVD_W = 38,
    parameter int DVS_W = 17
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             i_load,
    input  logic [DVD_W-1:0] i_dividend,
    input  logic [DVS_W-1:0] i_divisor,
    output logic             o_busy,
    output logic [DVD_W-1:0] o_quotient,
    output logic [DVS_W-1:0] o_remainder
);

    localparam int CNT_W = $clog2(DVD_W);

    logic [DVD_W-1:0] r_quo;
    logic [DVS_W-1:0] r_rem;
    logic [DVS_W-1:0] r_dvs;
    logic [CNT_W-1:0] r_cnt;

    logic [DVD_W-1:0] w_src_q;
    logic [DVS_W-1:0] w_src_rem;
    logic [DVS_W-1:0] w_dvs;
    logic [DVS_W:0]   w_shift;
    logic             w_ge;
    logic [DVS_W-1:0] w_rem_next;
    logic [DVD_W-1:0] w_quo_next;

    // The dividend register doubles as the quotient register: bits shift out on
    // the left while quotient bits shift in on the right.
    always_comb begin
        w_src_q    = i_load ? i_dividend : r_quo;
        w_src_rem  = i_load ? '0 : r_rem;
        w_dvs      = i_load ? i_divisor : r_dvs;
        w_shift    = {w_src_rem, w_src_q[DVD_W-1]};
        w_ge       = (w_shift >= {1'b0, w_dvs});
        w_rem_next = w_ge ? DVS_W'(w_shift - {1'b0, w_dvs}) : w_shift[DVS_W-1:0];
        w_quo_next = {w_src_q[DVD_W-2:0], w_ge};
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_quo <= '0;
            r_rem <= '0;
            r_dvs <= '0;
            r_cnt <= '0;
        end else if (i_load) begin
            r_quo <= w_quo_next;
            r_rem <= w_rem_next;
            r_dvs <= i_divisor;
            r_cnt <= CNT_W'(DVD_W - 1);
        end else if (r_cnt != '0) begin
            r_quo <= w_quo_next;
            r_rem <= w_rem_next;
            r_cnt <= r_cnt - CNT_W'(1);
        end
    end

    assign o_busy      = (r_cnt != '0);
    assign o_quotient  = r_quo;
    assign o_remainder = r_rem;

endmodule

// File: rtl/temperature_to_adc_encoder.sv
// Inverse of the temperature path: finds the sign-magnitude ADC code whose forward
// conversion lands on the target temperature, via shift-add square then long division.
module temperature_to_adc_encoder
    import temperature_to_adc_encoder_pkg::*;
#(
    parameter int SCALE_SHIFT = SCALE_SHIFT_DEF
) (
    input  logic                        clk,
    input  logic                        rst,
    temperature_to_adc_encoder_if.slave bus
);

    localparam int DVD_W    = TEMP_W + SCALE_SHIFT;
    localparam int DVS_W    = SQ_W + 1;
    localparam int SQ_CNT_W = $clog2(REF_W);

    state_t r_state, w_next;

    logic [REF_W-1:0]    r_ref;
    logic [TEMP_W-1:0]   r_mag;
    logic                r_sign;
    logic [SQ_W-1:0]     r_r2;
    logic [SQ_CNT_W-1:0] r_sq_cnt;

    logic [ADC_W-1:0]    r_adc;
    logic                r_ovf;
    logic                r_dz;

    logic [TEMP_W-1:0]   w_diff;
    logic [SQ_W-1:0]     w_pp;
    logic [SQ_W-1:0]     w_r2_next;
    logic                w_capture;
    logic                w_sq_last;
    logic                w_finish;
    logic                w_busy;
    logic                w_done;
    logic                w_div_busy;
    logic [DVD_W-1:0]    w_quo;
    logic [DVS_W-1:0]    w_rem;
    logic [ADC_W-1:0]    w_adc;
    logic                w_ovf;
    logic                w_dz;

    assign w_diff    = bus.tempc - bus.tc_base;
    assign w_capture = (r_state == ST_IDLE) && bus.start;
    assign w_sq_last = (r_state == ST_SQUARE) && (r_sq_cnt == SQ_CNT_W'(REF_W - 1));
    assign w_finish  = (r_state == ST_DIVIDE) && !w_div_busy;

    // One partial product per cycle, multiplier bits taken LSB first.
    always_comb begin
        w_pp      = r_ref[r_sq_cnt] ? (SQ_W'(r_ref) << r_sq_cnt) : '0;
        w_r2_next = r_r2 + w_pp;
    end

    // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state <= ST_IDLE;
        end else begin
            r_state <= w_next;
        end
    end

    // NOTE: every output of this block gets a default first, so no path can infer a latch.
    always_comb begin
        w_next = r_state;
        w_busy = 1'b0;
        w_done = 1'b0;
        unique case (r_state)
            ST_IDLE: begin
                if (bus.start) w_next = ST_SQUARE;
            end
            ST_SQUARE: begin
                w_busy = 1'b1;
                if (w_sq_last) w_next = ST_DIVIDE;
            end
            ST_DIVIDE: begin
                w_busy = 1'b1;
                if (!w_div_busy) w_next = ST_DONE;
            end
            ST_DONE: begin
                w_done = 1'b1;
                w_next = ST_IDLE;
            end
            default: w_next = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_ref    <= '0;
            r_mag    <= '0;
            r_sign   <= 1'b0;
            r_r2     <= '0;
            r_sq_cnt <= '0;
        end else if (w_capture) begin
            r_ref    <= bus.tc_ref;
            r_mag    <= abs_wrap(w_diff);
            r_sign   <= w_diff[TEMP_W-1];
            r_r2     <= '0;
            r_sq_cnt <= '0;
        end else if (r_state == ST_SQUARE) begin
            r_r2     <= w_r2_next;
            r_sq_cnt <= r_sq_cnt + SQ_CNT_W'(1);
        end
    end

    // The divisor is fed from the final squarer sum so division starts on the last square edge.
    seq_restoring_divider #(
        .DVD_W(DVD_W),
        .DVS_W(DVS_W)
    ) u_div (
        .clk        (clk),
        .rst        (rst),
        .i_load     (w_sq_last),
        .i_dividend ({r_mag, {SCALE_SHIFT{1'b0}}}),
        .i_divisor  ({1'b0, w_r2_next}),
        .o_busy     (w_div_busy),
        .o_quotient (w_quo),
        .o_remainder(w_rem)
    );

    // A zero reference voltage overrides whatever the divider produced.
    always_comb begin
        w_adc = {r_sign, w_quo[ADC_W-2:0]};
        w_ovf = 1'b0;
        w_dz  = 1'b0;
        if (r_r2 == '0) begin
            if (r_mag != '0) begin
                w_adc = {r_sign, ADC_MAG_MAX};
                w_dz  = 1'b1;
            end else begin
                w_adc = '0;
            end
        end else if (|w_quo[DVD_W-1:ADC_W-1]) begin
            w_adc = {r_sign, ADC_MAG_MAX};
            w_ovf = 1'b1;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_adc <= '0;
            r_ovf <= 1'b0;
            r_dz  <= 1'b0;
        end else if (w_finish) begin
            r_adc <= w_adc;
            r_ovf <= w_ovf;
            r_dz  <= w_dz;
            assert (r_r2 == '0 || w_rem < {1'b0, r_r2});
        end
    end

    assign bus.busy     = w_busy;
    assign bus.done     = w_done;
    assign bus.adc_data = r_adc;
    assign bus.overflow = r_ovf;
    assign bus.div_zero = r_dz;

endmodule
